// File: rtl/seq_divider_if.sv
// Handshake bundle for seq_divider: operand request channel and result channel.
// master = the upstream/downstream side, slave = the divider itself.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, in_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, in_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, unsigned or two's-complement.
// Divide by zero returns all-ones quotient and the untouched dividend as remainder.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_accept;
  logic             w_divZero;
  logic             w_lastStep;
  logic             w_dvdNeg;
  logic             w_dvsNeg;
  logic [WIDTH-1:0] w_dvdMag;
  logic [WIDTH-1:0] w_dvsMag;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_remStep;
  logic [WIDTH-1:0] w_quoStep;
  logic [WIDTH-1:0] w_quoFinal;
  logic [WIDTH-1:0] w_remFinal;

  assign w_divZero  = (bus.divisor == '0);
  assign w_dvdNeg   = bus.in_signed & bus.dividend[WIDTH-1];
  assign w_dvsNeg   = bus.in_signed & bus.divisor[WIDTH-1];
  assign w_dvdMag   = w_dvdNeg ? -bus.dividend : bus.dividend;
  assign w_dvsMag   = w_dvsNeg ? -bus.divisor  : bus.divisor;
  assign w_lastStep = (r_count == '0);

  // The partial remainder is always below the divisor, so the borrow of the
  // WIDTH+1 bit subtraction is exactly the "does not fit" decision.
  assign w_remShift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvsr};
  assign w_remStep  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quoStep  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_quoFinal = r_negQ ? -w_quoStep : w_quoStep;
  assign w_remFinal = r_negR ? -w_remStep : w_remStep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        w_accept  = bus.in_valid;
        if (bus.in_valid) begin
          w_nextState = w_divZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Result registers only change when a new result is produced, so they hold
  // through DONE and keep their last value after the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= CW'(WIDTH - 1);
        r_rem   <= '0;
        r_quo   <= w_dvdMag;
        r_dvsr  <= w_dvsMag;
        r_negQ  <= w_dvdNeg ^ w_dvsNeg;
        r_negR  <= w_dvdNeg;
        if (w_divZero) begin
          r_quotient  <= '1;
          r_remainder <= bus.dividend;
          r_dbz       <= 1'b1;
        end
      end else if (r_state == BUSY) begin
        r_rem   <= w_remStep;
        r_quo   <= w_quoStep;
        r_count <= r_count - 1'b1;
        if (w_lastStep) begin
          r_quotient  <= w_quoFinal;
          r_remainder <= w_remFinal;
          r_dbz       <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready    = w_inReady;
  assign bus.out_valid   = w_outValid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule
